// File: rtl/shift_reg_seq_pkg.sv
// Shared types and encodings for the shift register sequencer.
// States, register mode codes and serial fill codes.
package shift_reg_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  localparam logic [1:0] FILL_ZERO  = 2'b00;
  localparam logic [1:0] FILL_ONE   = 2'b01;
  localparam logic [1:0] FILL_ROT   = 2'b10;
  localparam logic [1:0] FILL_ARITH = 2'b11;

endpackage

// File: rtl/shift_reg_seq_fill_sel.sv
// Serial fill selection for the universal shift register.
// Only the input on the active shift side is driven.
module shift_fill_sel
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             dir,
  input  logic [1:0]       fill,
  input  logic [WIDTH-1:0] q_fb,
  output logic             shr_in,
  output logic             shl_in
);

  logic fin;

  always_comb begin
    fin = 1'b0;
    unique case (1'b1)
      fill == FILL_ZERO:  fin = 1'b0;
      fill == FILL_ONE:   fin = 1'b1;
      fill == FILL_ROT:   fin = dir ? q_fb[WIDTH-1] : q_fb[0];
      fill == FILL_ARITH: fin = dir ? 1'b0 : q_fb[WIDTH-1];
      default:            fin = 1'b0;
    endcase
  end

  assign shr_in = ~dir & fin;
  assign shl_in = dir & fin;

endmodule

// File: rtl/shift_reg_seq.sv
// Command sequencer: optional parallel load, then N single-place
// shifts on an external 4-bit universal shift register.
module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [1:0]       cmd_fill,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] q_fb,
  output logic [1:0]       s1s0,
  output logic             shr_in,
  output logic             shl_in,
  output logic [WIDTH-1:0] ld_data,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic             dir_q;
  logic [1:0]       fill_q;
  logic [AMT_W-1:0] amt_q;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode;
  logic             accept;

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ld_data <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      fill_q  <= FILL_ZERO;
      amt_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            dir_q   <= cmd_dir;
            fill_q  <= cmd_fill;
            amt_q   <= cmd_amt;
            ld_data <= cmd_data;
            cnt     <= '0;
            if (cmd_load)
              state <= S_LOAD;
            else if (cmd_amt != '0)
              state <= S_SHIFT;
            else
              state <= S_DONE;
          end
        end
        S_LOAD: begin
          state <= (amt_q != '0) ? S_SHIFT : S_DONE;
        end
        S_SHIFT: begin
          if (cnt == amt_q - 1'b1) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mode = MODE_HOLD;
    unique case (1'b1)
      state == S_LOAD:  mode = MODE_LOAD;
      state == S_SHIFT: mode = dir_q ? MODE_SHL : MODE_SHR;
      default:          mode = MODE_HOLD;
    endcase
  end

  // Reset must stop the register immediately, not one edge later.
  assign s1s0      = rst ? MODE_HOLD : mode;
  assign cmd_ready = (state == S_IDLE) & ~rst;
  assign busy      = (state != S_IDLE) & ~rst;
  assign done      = (state == S_DONE) & ~rst;

  shift_fill_sel #(
    .WIDTH(WIDTH)
  ) u_fill (
    .dir   (dir_q),
    .fill  (fill_q),
    .q_fb  (q_fb),
    .shr_in(shr_in),
    .shl_in(shl_in)
  );

endmodule
